// File: rtl/chicken_pkg.sv
// Shared types and constants for the turn scheduler.
// Holds the FSM state encoding, the player index type and the
// num_players encoding, plus a helper that maps an encoding to the
// index of the last player in the rotation.
package chicken_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  typedef logic [1:0] player_t;

  // num_players encodings
  localparam logic [1:0] NP_2  = 2'b00;
  localparam logic [1:0] NP_3  = 2'b01;
  localparam logic [1:0] NP_4  = 2'b10;
  localparam logic [1:0] NP_4B = 2'b11;

  // Index of the last player before the rotation wraps to 0.
  function automatic player_t last_index(input logic [1:0] np);
    player_t idx;
    case (np)
      NP_2:    idx = 2'd1;
      NP_3:    idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-turn cycle counter. Counts while run is high, restarts from 0 on
// clear, and flags expired in the cycle where LIMIT-1 cycles have
// elapsed since the last clear. Only built when TURN_SCHEDULER_TIMEOUT_EN
// is defined.
module turn_timer #(
  parameter logic [31:0] LIMIT = 32'd250_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [31:0] cnt_q;

  // Cycle counter; holds at the limit until the owner clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 32'd0;
    end else if (clear) begin
      cnt_q <= 32'd0;
    end else if (run && !expired) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign expired = run && (cnt_q == LIMIT - 32'd1);

endmodule

// File: rtl/turn_scheduler.sv
// Turn scheduler for a 2..4 player board game.
// FSM IDLE -> PLAY -> OVER; start (from IDLE or OVER) begins a game with
// the player count latched at that moment. All outputs are registered.
// Compile-time option: TURN_SCHEDULER_TIMEOUT_EN adds a per-turn timer
// that forces a handover after TIMEOUT_CYCLES idle cycles.
// Handshake: start, turn_done and game_won are single-cycle pulses with no
// back-pressure; each is acted on in the cycle it is high, and the
// resulting outputs appear after the next rising edge.
module turn_scheduler
  import chicken_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd250_000_000,
  parameter int          CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       num_players,
  input  logic             start,
  input  logic             turn_done,
  input  logic             keep_turn,
  input  logic             game_won,
  output logic [1:0]       cur_player,
  output logic             turn_active,
  output logic             new_turn,
  output logic [CNT_W-1:0] turn_count,
  output logic             game_over,
  output logic [1:0]       winner,
  output logic             timeout,
  output state_t           state_dbg
);

  state_t           state_q, state_d;
  player_t          last_q, last_d;
  player_t          cur_q, cur_d;
  player_t          winner_q, winner_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             new_turn_d;
  logic             timeout_d;
  logic             expired;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start enters PLAY from IDLE/OVER, game_won ends play
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, OVER: if (start)    state_d = PLAY;
      PLAY:       if (game_won) state_d = OVER;
      default:                  state_d = IDLE;
    endcase
  end

  // Next output values: game_won beats turn_done, which beats a timeout
  always_comb begin
    last_d     = last_q;
    cur_d      = cur_q;
    winner_d   = winner_q;
    count_d    = count_q;
    new_turn_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          last_d     = last_index(num_players);
          cur_d      = 2'd0;
          count_d    = '0;
          winner_d   = 2'd0;
          new_turn_d = 1'b1;
        end
      end
      PLAY: begin
        if (game_won) begin
          winner_d = cur_q;
        end else if ((turn_done && !keep_turn) || (!turn_done && expired)) begin
          cur_d      = (cur_q == last_q) ? 2'd0 : cur_q + 2'd1;
          count_d    = (&count_q) ? count_q : count_q + 1'b1;
          new_turn_d = 1'b1;
          timeout_d  = !turn_done;
        end
      end
      default: ;
    endcase
  end

  // Output and bookkeeping registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q      <= 2'd1;
      cur_q       <= 2'd0;
      winner_q    <= 2'd0;
      count_q     <= '0;
      new_turn    <= 1'b0;
      timeout     <= 1'b0;
      turn_active <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      last_q      <= last_d;
      cur_q       <= cur_d;
      winner_q    <= winner_d;
      count_q     <= count_d;
      new_turn    <= new_turn_d;
      timeout     <= timeout_d;
      turn_active <= (state_d == PLAY);
      game_over   <= (state_d == OVER);
    end
  end

  assign cur_player = cur_q;
  assign winner     = winner_q;
  assign turn_count = count_q;
  assign state_dbg  = state_q;

`ifdef TURN_SCHEDULER_TIMEOUT_EN
  logic timer_clear;
  logic timer_run;

  // Restart the turn clock on every handover and on a kept turn.
  assign timer_clear = new_turn_d ||
                       ((state_q == PLAY) && !game_won && turn_done && keep_turn);
  assign timer_run   = (state_q == PLAY);

  turn_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_turn_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .run     (timer_run),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

endmodule

// File: doc/turn_scheduler.md
TURN_SCHEDULER -- requirements
Module: turn_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 32'd250_000_000, sets the per-turn time limit in clk cycles (5 s at 50 MHz).
REQ-002 Parameter CNT_W, default 8, sets the width of turn_count.
REQ-003 Port clk, input, 1 bit, is the single system clock, and all logic SHALL be rising-edge.
REQ-004 Port rst, input, 1 bit, is the reset: asynchronous, active-high.
REQ-005 Port num_players, input, 2 bits, sets player count: 00=2, 01=3, 10=4, 11=4.
REQ-006 Port start, input, 1 bit, is a one-cycle pulse that begins or restarts a game.
REQ-007 Port turn_done, input, 1 bit, is a one-cycle pulse meaning the current player's move has resolved.
REQ-008 Port keep_turn, input, 1 bit, is qualified by turn_done: 1 means correct tile guess and the same player continues.
REQ-009 Port game_won, input, 1 bit, is a one-cycle pulse meaning the current player has won.
REQ-010 Port cur_player, output, 2 bits, is the index of the player holding the turn.
REQ-011 Port turn_active, output, 1 bit, SHALL be high only in PLAY.
REQ-012 Port new_turn, output, 1 bit, is a one-cycle pulse issued whenever a player newly gains the turn.
REQ-013 Port turn_count, output, CNT_W bits, counts completed turn handovers and saturates at all-ones.
REQ-014 Port game_over, output, 1 bit, SHALL be high in OVER.
REQ-015 Port winner, output, 2 bits, holds the winning player index and is valid while game_over is high.
REQ-016 Port timeout, output, 1 bit, is a one-cycle pulse issued when a turn is forced to end.

Function
REQ-017 FSM states SHALL be IDLE, PLAY and OVER, and all outputs SHALL be registered.
REQ-018 In IDLE, start SHALL latch num_players into an internal count, then: cur_player=0, turn_count=0, go to PLAY, new_turn=1 on the next cycle.
REQ-019 In PLAY, turn_done with keep_turn=1 SHALL leave cur_player unchanged and SHALL NOT pulse new_turn.
REQ-020 In PLAY, turn_done with keep_turn=0 SHALL, on the next edge, set cur_player to cur_player+1, wrapping to 0 after the last player, pulse new_turn, and increment turn_count; latency is 1 cycle.
REQ-021 The wrap point SHALL use the count latched at start; num_players changes mid-game SHALL be ignored.
REQ-022 In PLAY, game_won SHALL set winner=cur_player and go to OVER; it takes priority over turn_done and timeout in the same cycle.
REQ-023 start SHALL be ignored in PLAY.
REQ-024 In OVER, start SHALL behave as in IDLE; turn_done and game_won SHALL be ignored.
REQ-025 winner SHALL hold its value until the next start, which SHALL clear it to 0.
REQ-026 turn_done and game_won SHALL be ignored in IDLE.
REQ-027 new_turn and timeout SHALL never be high for more than one consecutive cycle without a new triggering event.

Reset
REQ-028 rst high SHALL immediately force IDLE, cur_player=0, turn_count=0, winner=0, turn_active=0, new_turn=0, game_over=0, timeout=0, latched count=2 players, and timer=0, including mid-turn.
REQ-029 The first rising clk edge after rst falls SHALL already see IDLE.

Configuration
REQ-030 The macro TURN_SCHEDULER_TIMEOUT_EN SHALL be the single compile-time option.
REQ-031 With TURN_SCHEDULER_TIMEOUT_EN defined: a timer SHALL count clk cycles in PLAY.
REQ-032 With TURN_SCHEDULER_TIMEOUT_EN defined: the timer SHALL clear on every new_turn and on turn_done with keep_turn=1.
REQ-033 With TURN_SCHEDULER_TIMEOUT_EN defined: when the timer reaches TIMEOUT_CYCLES-1, the block SHALL pulse timeout and advance exactly as for turn_done with keep_turn=0.
REQ-034 With TURN_SCHEDULER_TIMEOUT_EN defined: turn_done arriving in the same cycle as the expiry SHALL take precedence, with no timeout pulse.
REQ-035 Without the macro: no timer SHALL exist, timeout SHALL be tied 0, and TIMEOUT_CYCLES SHALL be unused.

Structure
REQ-036 A shared package chicken_pkg SHALL hold the FSM state enum (IDLE/PLAY/OVER), the player index typedef (2 bits), and the num_players encoding constants.
REQ-037 The timer SHALL be a sub-module turn_timer with ports clk, rst, clear, run, expired, instantiated only under TURN_SCHEDULER_TIMEOUT_EN.

Verification
REQ-038 Reset then start with num_players=01, then three turn_done with keep_turn=0 -> cur_player 0,1,2,0; four new_turn pulses total; turn_count=3.
REQ-039 num_players=00 in PLAY, turn_done with keep_turn=1 five times -> cur_player stays 0, no new_turn, turn_count=0.
REQ-040 num_players=10, cur_player=3, turn_done and game_won in the same cycle -> OVER, winner=3, cur_player=3, turn_count unchanged.
REQ-041 num_players changed 10->00 mid-game -> rotation still 0..3; start in OVER -> PLAY, cur_player=0, winner=0.
REQ-042 With the macro and TIMEOUT_CYCLES=16, idle turn -> timeout pulse 16 cycles after new_turn and cur_player advances; turn_done at cycle 15 -> no timeout.
REQ-043 rst asserted mid-PLAY between edges -> outputs are at reset values before the next edge.
